// File: rtl/aes_latency_monitor.sv
// Start->done latency monitor for NUM_CH AES engines: per-channel measurement,
// one-deep result slots, round-robin merge into shared count/min/max/sum stats.
// Optional histogram storage and readout when AES_LATMON_HIST_EN is defined.
module aes_latency_monitor #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned SUM_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned HIST_BINS      = 64,
  parameter int unsigned HC_W           = 16,
  localparam int unsigned HB_W          = $clog2(HIST_BINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] done,
  input  logic              clear,
  output logic [31:0]       txn_count,
  output logic [CNT_W-1:0]  lat_min,
  output logic [CNT_W-1:0]  lat_max,
  output logic [SUM_W-1:0]  lat_sum,
  output logic [NUM_CH-1:0] timeout_flag,
  output logic [NUM_CH-1:0] overlap_err,
  output logic [NUM_CH-1:0] drop_err,
  input  logic [HB_W-1:0]   hist_rd_bin,
  output logic [HC_W-1:0]   hist_rd_data
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, MEAS} ch_state_e;

  ch_state_e         state_q    [NUM_CH];
  ch_state_e         state_d    [NUM_CH];
  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  slot_lat_q [NUM_CH];
  logic [CNT_W-1:0]  slot_lat_d [NUM_CH];
  logic [NUM_CH-1:0] slot_vld_q, slot_vld_d;
  logic [NUM_CH-1:0] timeout_d, overlap_d, drop_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;
  logic [NUM_CH-1:0] gnt;
  logic [CNT_W-1:0]  gnt_lat;
  logic [SUM_W:0]    sum_ext;

  // Channel index 'off' positions after 'base', wrapping at NUM_CH
  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int unsigned off);
    rr_idx = CH_W'((32'(base) + off) % NUM_CH);
  endfunction

  // Round-robin pick of the first valid slot at or after the pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!gnt_vld && slot_vld_q[rr_idx(ptr_q, j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(ptr_q, j);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      gnt[i] = gnt_vld && (gnt_idx == CH_W'(i));
    end
  end

  assign gnt_lat = slot_lat_q[gnt_idx];
  assign sum_ext = (SUM_W+1)'(lat_sum) + (SUM_W+1)'(gnt_lat);

  // Channel FSM next state, result slot writes/drains and sticky error flags
  always_comb begin
    ptr_d      = ptr_q;
    slot_vld_d = slot_vld_q;
    timeout_d  = timeout_flag;
    overlap_d  = overlap_err;
    drop_d     = drop_err;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      slot_lat_d[i] = slot_lat_q[i];
    end
    if (clear) begin
      ptr_d      = '0;
      slot_vld_d = '0;
      timeout_d  = '0;
      overlap_d  = '0;
      drop_d     = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end
    end else begin
      if (gnt_vld) ptr_d = rr_idx(gnt_idx, 1);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (gnt[i]) slot_vld_d[i] = 1'b0;
        case (state_q[i])
          IDLE: begin
            if (start[i]) begin
              state_d[i] = MEAS;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          MEAS: begin
            if (done[i]) begin
              // A slot being drained this cycle can accept the new result
              if (slot_vld_q[i] && !gnt[i]) begin
                drop_d[i] = 1'b1;
              end else begin
                slot_vld_d[i] = 1'b1;
                slot_lat_d[i] = cnt_q[i];
              end
              if (start[i]) begin
                cnt_d[i] = CNT_W'(1);
              end else begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
              end
            end else if (start[i]) begin
              overlap_d[i] = 1'b1;
              cnt_d[i]     = CNT_W'(1);
            end else if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES)) begin
              timeout_d[i] = 1'b1;
              state_d[i]   = IDLE;
              cnt_d[i]     = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // Channel state, slot and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= IDLE;
        cnt_q[i]      <= '0;
        slot_lat_q[i] <= '0;
      end
      slot_vld_q   <= '0;
      ptr_q        <= '0;
      timeout_flag <= '0;
      overlap_err  <= '0;
      drop_err     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        slot_lat_q[i] <= slot_lat_d[i];
      end
      slot_vld_q   <= slot_vld_d;
      ptr_q        <= ptr_d;
      timeout_flag <= timeout_d;
      overlap_err  <= overlap_d;
      drop_err     <= drop_d;
    end
  end

  // Shared statistics update from the drained slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
    end else if (clear) begin
      txn_count <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
    end else if (gnt_vld) begin
      if (txn_count != '1) txn_count <= txn_count + 32'd1;
      if (gnt_lat < lat_min) lat_min <= gnt_lat;
      if (gnt_lat > lat_max) lat_max <= gnt_lat;
      lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    end
  end

`ifdef AES_LATMON_HIST_EN
  logic [HC_W-1:0] hist_q [HIST_BINS];
  logic [HB_W-1:0] hist_bin;

  assign hist_bin = (gnt_lat >= CNT_W'(HIST_BINS - 1)) ? HB_W'(HIST_BINS - 1) : HB_W'(gnt_lat);

  // Saturating histogram bins, cleared in a single cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < HIST_BINS; b++) hist_q[b] <= '0;
    end else if (clear) begin
      for (int unsigned b = 0; b < HIST_BINS; b++) hist_q[b] <= '0;
    end else if (gnt_vld && (hist_q[hist_bin] != '1)) begin
      hist_q[hist_bin] <= hist_q[hist_bin] + HC_W'(1);
    end
  end

  // Registered histogram readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_rd_data <= '0;
    end else if (clear) begin
      hist_rd_data <= '0;
    end else begin
      hist_rd_data <= hist_q[hist_rd_bin];
    end
  end
`else
  logic unused_hist_rd_bin;
  assign unused_hist_rd_bin = ^hist_rd_bin;
  assign hist_rd_data       = '0;
`endif

endmodule

// File: tb/tb_aes_latency_monitor.sv
// Directed self-checking bench for aes_latency_monitor (default parameters).
module tb_aes_latency_monitor;

  localparam int unsigned NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] start, done;
  logic              clear;
  logic [31:0]       txn_count;
  logic [15:0]       lat_min, lat_max;
  logic [31:0]       lat_sum;
  logic [NUM_CH-1:0] timeout_flag, overlap_err, drop_err;
  logic [5:0]        hist_rd_bin;
  logic [15:0]       hist_rd_data;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef AES_LATMON_HIST_EN
  localparam logic [15:0] HIST_ONE = 16'd1;
`else
  localparam logic [15:0] HIST_ONE = 16'd0;
`endif

  aes_latency_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .done         (done),
    .clear        (clear),
    .txn_count    (txn_count),
    .lat_min      (lat_min),
    .lat_max      (lat_max),
    .lat_sum      (lat_sum),
    .timeout_flag (timeout_flag),
    .overlap_err  (overlap_err),
    .drop_err     (drop_err),
    .hist_rd_bin  (hist_rd_bin),
    .hist_rd_data (hist_rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic read_hist(input logic [5:0] bin, output logic [15:0] val);
    hist_rd_bin = bin;
    tick();
    val = hist_rd_data;
  endtask

  // Single-channel transaction on ch0 with latency n
  task automatic run_ch0(input int n);
    start = 4'b0001;
    tick();
    start = '0;
    repeat (n - 1) tick();
    done = 4'b0001;
    tick();
    done = '0;
  endtask

  task automatic test_reset();
    logic [15:0] h;
    tests_run++; if (txn_count !== 32'd0) begin tests_failed++; $display("FAIL reset_txn: got %0d want 0", txn_count); end
    tests_run++; if (lat_min !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_min: got %0h want ffff", lat_min); end
    tests_run++; if (lat_max !== 16'd0) begin tests_failed++; $display("FAIL reset_max: got %0d want 0", lat_max); end
    tests_run++; if (lat_sum !== 32'd0) begin tests_failed++; $display("FAIL reset_sum: got %0d want 0", lat_sum); end
    tests_run++; if ({timeout_flag, overlap_err, drop_err} !== 12'd0) begin tests_failed++; $display("FAIL reset_flags: got %0h want 0", {timeout_flag, overlap_err, drop_err}); end
    read_hist(6'd0, h);
    tests_run++; if (h !== 16'd0) begin tests_failed++; $display("FAIL reset_hist0: got %0d want 0", h); end
  endtask

  task automatic test_single();
    logic [15:0] h;
    run_ch0(11);
    repeat (3) tick();
    tests_run++; if (txn_count !== 32'd1) begin tests_failed++; $display("FAIL single_txn: got %0d want 1", txn_count); end
    tests_run++; if (lat_min !== 16'd11) begin tests_failed++; $display("FAIL single_min: got %0d want 11", lat_min); end
    tests_run++; if (lat_max !== 16'd11) begin tests_failed++; $display("FAIL single_max: got %0d want 11", lat_max); end
    tests_run++; if (lat_sum !== 32'd11) begin tests_failed++; $display("FAIL single_sum: got %0d want 11", lat_sum); end
    read_hist(6'd11, h);
    tests_run++; if (h !== HIST_ONE) begin tests_failed++; $display("FAIL single_hist11: got %0d want %0d", h, HIST_ONE); end
    read_hist(6'd10, h);
    tests_run++; if (h !== 16'd0) begin tests_failed++; $display("FAIL single_hist10: got %0d want 0", h); end
  endtask

  task automatic test_simultaneous();
    do_clear();
    // Staggered starts so all four finish on one edge with latencies 5,6,7,8
    start = 4'b1000; tick();
    start = 4'b0100; tick();
    start = 4'b0010; tick();
    start = 4'b0001; tick();
    start = '0;
    repeat (4) tick();
    done = 4'b1111; tick();
    done = '0;
    tick();
    tests_run++; if (txn_count !== 32'd1) begin tests_failed++; $display("FAIL simul_first_drain: got %0d want 1", txn_count); end
    repeat (3) tick();
    tests_run++; if (txn_count !== 32'd4) begin tests_failed++; $display("FAIL simul_txn: got %0d want 4", txn_count); end
    tests_run++; if (lat_min !== 16'd5) begin tests_failed++; $display("FAIL simul_min: got %0d want 5", lat_min); end
    tests_run++; if (lat_max !== 16'd8) begin tests_failed++; $display("FAIL simul_max: got %0d want 8", lat_max); end
    tests_run++; if (lat_sum !== 32'd26) begin tests_failed++; $display("FAIL simul_sum: got %0d want 26", lat_sum); end
    tests_run++; if (drop_err !== 4'd0) begin tests_failed++; $display("FAIL simul_drop: got %0h want 0", drop_err); end
  endtask

  task automatic test_timeout();
    do_clear();
    start = 4'b0010; tick();
    start = '0;
    repeat (1999) tick();
    tests_run++; if (timeout_flag !== 4'b0000) begin tests_failed++; $display("FAIL timeout_early: got %0h want 0", timeout_flag); end
    tick();
    tests_run++; if (timeout_flag !== 4'b0010) begin tests_failed++; $display("FAIL timeout_flag: got %0h want 2", timeout_flag); end
    // A late done must be ignored because the channel is back in IDLE
    done = 4'b0010; tick();
    done = '0;
    repeat (3) tick();
    tests_run++; if (txn_count !== 32'd0) begin tests_failed++; $display("FAIL timeout_txn: got %0d want 0", txn_count); end
  endtask

  task automatic test_overlap();
    do_clear();
    start = 4'b0100; tick();
    start = '0; repeat (2) tick();
    start = 4'b0100; tick();
    start = '0; repeat (3) tick();
    done = 4'b0100; tick();
    done = '0;
    repeat (3) tick();
    tests_run++; if (overlap_err !== 4'b0100) begin tests_failed++; $display("FAIL overlap_flag: got %0h want 4", overlap_err); end
    tests_run++; if (txn_count !== 32'd1) begin tests_failed++; $display("FAIL overlap_txn: got %0d want 1", txn_count); end
    tests_run++; if (lat_sum !== 32'd4) begin tests_failed++; $display("FAIL overlap_lat: got %0d want 4", lat_sum); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    start = 4'b0001; tick();
    start = '0; repeat (2) tick();
    start = 4'b0001; done = 4'b0001; tick();
    start = '0; done = '0; repeat (3) tick();
    done = 4'b0001; tick();
    done = '0;
    repeat (3) tick();
    tests_run++; if (txn_count !== 32'd2) begin tests_failed++; $display("FAIL b2b_txn: got %0d want 2", txn_count); end
    tests_run++; if (lat_min !== 16'd3) begin tests_failed++; $display("FAIL b2b_min: got %0d want 3", lat_min); end
    tests_run++; if (lat_max !== 16'd4) begin tests_failed++; $display("FAIL b2b_max: got %0d want 4", lat_max); end
    tests_run++; if (lat_sum !== 32'd7) begin tests_failed++; $display("FAIL b2b_sum: got %0d want 7", lat_sum); end
  endtask

  task automatic test_hist_clip_and_clear();
    logic [15:0] h;
    do_clear();
    run_ch0(100);
    repeat (3) tick();
    tests_run++; if (lat_max !== 16'd100) begin tests_failed++; $display("FAIL clip_max: got %0d want 100", lat_max); end
    read_hist(6'd63, h);
    tests_run++; if (h !== HIST_ONE) begin tests_failed++; $display("FAIL clip_hist63: got %0d want %0d", h, HIST_ONE); end
    // Raise a sticky flag too so clear has something to wipe
    start = 4'b1000; tick();
    start = 4'b1000; tick();
    start = '0;
    do_clear();
    tests_run++; if (txn_count !== 32'd0) begin tests_failed++; $display("FAIL clear_txn: got %0d want 0", txn_count); end
    tests_run++; if (lat_min !== 16'hFFFF) begin tests_failed++; $display("FAIL clear_min: got %0h want ffff", lat_min); end
    tests_run++; if (lat_max !== 16'd0) begin tests_failed++; $display("FAIL clear_max: got %0d want 0", lat_max); end
    tests_run++; if (lat_sum !== 32'd0) begin tests_failed++; $display("FAIL clear_sum: got %0d want 0", lat_sum); end
    tests_run++; if (overlap_err !== 4'd0) begin tests_failed++; $display("FAIL clear_overlap: got %0h want 0", overlap_err); end
    read_hist(6'd63, h);
    tests_run++; if (h !== 16'd0) begin tests_failed++; $display("FAIL clear_hist63: got %0d want 0", h); end
    // ch3 was mid-measurement at clear, so a done now must be ignored
    done = 4'b1000; tick();
    done = '0;
    repeat (3) tick();
    tests_run++; if (txn_count !== 32'd0) begin tests_failed++; $display("FAIL clear_fsm_idle: got %0d want 0", txn_count); end
  endtask

  task automatic test_async_reset();
    start = 4'b0001; tick();
    start = '0; repeat (3) tick();
    rst_n = 1'b0;
    #2;
    tests_run++; if (lat_min !== 16'hFFFF) begin tests_failed++; $display("FAIL arst_min: got %0h want ffff", lat_min); end
    tick();
    rst_n = 1'b1;
    tick();
    done = 4'b0001; tick();
    done = '0;
    repeat (3) tick();
    tests_run++; if (txn_count !== 32'd0) begin tests_failed++; $display("FAIL arst_no_record: got %0d want 0", txn_count); end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = '0;
    done        = '0;
    clear       = 1'b0;
    hist_rd_bin = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_simultaneous();
    test_timeout();
    test_overlap();
    test_back_to_back();
    test_hist_clip_and_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
